// File: rtl/axi4_lite_master_read_arbiter.sv
// Round-robin arbiter in front of a single-outstanding AXI4-Lite read master.
// NUM_REQ requesters compete for one AXI read channel. The winner's address is
// latched, issued on AR, and the R beat is returned to that requester as a
// one-cycle rsp_valid strobe. Per-phase wait counters raise a one-cycle timeout
// pulse while the FSM keeps waiting so the AXI handshake rules are never broken.
module axi4_lite_master_read_arbiter #(
  parameter int unsigned NUM_REQ          = 4,
  parameter int unsigned ADDR_WIDTH       = 32,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned MAX_DELAY_READY  = 16,
  parameter int unsigned MAX_DELAY_RVALID = 10
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  // Requester side
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [1:0]                    rsp_resp,
  // AXI4-Lite read address channel
  output logic [ADDR_WIDTH-1:0]         araddr,
  output logic [2:0]                    arprot,
  output logic                          arvalid,
  input  logic                          arready,
  // AXI4-Lite read data channel
  input  logic [DATA_WIDTH-1:0]         rdata,
  input  logic [1:0]                    rresp,
  input  logic                          rvalid,
  output logic                          rready,
  // Status
  output logic                          timeout_err,
  output logic [1:0]                    timeout_src
);

  localparam int unsigned IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned AR_CNT_W = $clog2(MAX_DELAY_READY + 1);
  localparam int unsigned R_CNT_W  = $clog2(MAX_DELAY_RVALID + 1);

  localparam logic [IDX_W:0]      NUM_REQ_EXT = (IDX_W + 1)'(NUM_REQ);
  localparam logic [IDX_W-1:0]    LAST_IDX    = IDX_W'(NUM_REQ - 1);
  localparam logic [AR_CNT_W-1:0] AR_LIMIT    = AR_CNT_W'(MAX_DELAY_READY);
  localparam logic [AR_CNT_W-1:0] AR_PRE      = AR_CNT_W'(MAX_DELAY_READY - 1);
  localparam logic [R_CNT_W-1:0]  R_LIMIT     = R_CNT_W'(MAX_DELAY_RVALID);
  localparam logic [R_CNT_W-1:0]  R_PRE       = R_CNT_W'(MAX_DELAY_RVALID - 1);

  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_AR   = 2'b01;
  localparam logic [1:0] SRC_R    = 2'b10;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAddr = 2'd1,
    StData = 2'd2
  } state_e;

  state_e                  r_state;
  state_e                  w_state_next;

  // r_last_grant doubles as the owner of the outstanding transaction: it only
  // changes on acceptance and there is never more than one transaction in flight.
  logic [IDX_W-1:0]        r_last_grant;
  logic [ADDR_WIDTH-1:0]   r_araddr;
  logic [NUM_REQ-1:0]      r_rsp_valid;
  logic [DATA_WIDTH-1:0]   r_rsp_data;
  logic [1:0]              r_rsp_resp;
  logic [AR_CNT_W-1:0]     r_ar_cnt;
  logic [R_CNT_W-1:0]      r_r_cnt;
  logic                    r_timeout_err;
  logic [1:0]              r_timeout_src;

  logic                    w_grant_found;
  logic [IDX_W-1:0]        w_grant_idx;
  logic [IDX_W:0]          w_cand;
  logic [ADDR_WIDTH-1:0]   w_win_addr;
  logic                    w_accept;
  logic                    w_r_hs;
  logic                    w_ar_wait;
  logic                    w_r_wait;

  // Round-robin search starting one past the last grant, wrapping at NUM_REQ.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    w_cand        = '0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      w_cand = {1'b0, r_last_grant} + (IDX_W + 1)'(k);
      if (w_cand >= NUM_REQ_EXT) begin
        w_cand = w_cand - NUM_REQ_EXT;
      end
      if (!w_grant_found && req_valid[w_cand[IDX_W-1:0]]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = w_cand[IDX_W-1:0];
      end
    end
  end

  // Select the winning requester's address slice.
  always_comb begin
    w_win_addr = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (w_grant_idx == IDX_W'(i)) begin
        w_win_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Next-state and handshake outputs; req_ready is masked during reset so no
  // grant is advertised while the block is held in reset.
  always_comb begin
    w_state_next = r_state;
    req_ready    = '0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_grant_found && aresetn) begin
          req_ready[w_grant_idx] = 1'b1;
          w_state_next           = StAddr;
        end
      end
      StAddr: begin
        arvalid = 1'b1;
        if (arready) begin
          w_state_next = StData;
        end
      end
      StData: begin
        rready = 1'b1;
        if (rvalid) begin
          w_state_next = StIdle;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  assign w_accept  = |req_ready;
  assign w_r_hs    = rready & rvalid;
  assign w_ar_wait = (r_state == StAddr) & ~arready;
  assign w_r_wait  = (r_state == StData) & ~rvalid;

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Latch winner index and address on acceptance; later req_addr changes are ignored.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_last_grant <= LAST_IDX;
      r_araddr     <= '0;
    end else if (w_accept) begin
      r_last_grant <= w_grant_idx;
      r_araddr     <= w_win_addr;
    end
  end

  // Capture the R beat; rsp_valid strobes the owner for one cycle, data is held.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rsp_resp  <= '0;
    end else begin
      r_rsp_valid <= '0;
      if (w_r_hs) begin
        r_rsp_valid[r_last_grant] <= 1'b1;
        r_rsp_data                <= rdata;
        r_rsp_resp                <= rresp;
      end
    end
  end

  // AR wait counter: consecutive ADDR cycles without arready, saturating.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_ar_cnt <= '0;
    end else if (w_ar_wait) begin
      if (r_ar_cnt != AR_LIMIT) begin
        r_ar_cnt <= r_ar_cnt + AR_CNT_W'(1);
      end
    end else begin
      r_ar_cnt <= '0;
    end
  end

  // R wait counter: consecutive DATA cycles without rvalid, saturating.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_r_cnt <= '0;
    end else if (w_r_wait) begin
      if (r_r_cnt != R_LIMIT) begin
        r_r_cnt <= r_r_cnt + R_CNT_W'(1);
      end
    end else begin
      r_r_cnt <= '0;
    end
  end

  // Timeout pulse fires once, on the edge where a counter reaches its limit.
  // A handshake in that cycle stops the count, so it wins over the timeout.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_timeout_err <= 1'b0;
      r_timeout_src <= SRC_NONE;
    end else begin
      r_timeout_err <= 1'b0;
      r_timeout_src <= SRC_NONE;
      if (w_ar_wait && (r_ar_cnt == AR_PRE)) begin
        r_timeout_err <= 1'b1;
        r_timeout_src <= SRC_AR;
      end else if (w_r_wait && (r_r_cnt == R_PRE)) begin
        r_timeout_err <= 1'b1;
        r_timeout_src <= SRC_R;
      end
    end
  end

  assign araddr      = r_araddr;
  assign arprot      = 3'b000;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign rsp_resp    = r_rsp_resp;
  assign timeout_err = r_timeout_err;
  assign timeout_src = r_timeout_src;

endmodule

// File: tb/tb_axi4_lite_master_read_arbiter.sv
// Bench for axi4_lite_master_read_arbiter: directed scenarios plus randomized
// transactions, checked cycle by cycle against a transaction-level model.
module tb_axi4_lite_master_read_arbiter;

  localparam int unsigned N    = 4;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned MAXA = 16;
  localparam int unsigned MAXR = 10;

  logic            aclk = 1'b0;
  logic            aresetn;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic [1:0]      rsp_resp;
  logic [AW-1:0]   araddr;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;
  logic            timeout_err;
  logic [1:0]      timeout_src;

  always #5 aclk = ~aclk;

  axi4_lite_master_read_arbiter #(
    .NUM_REQ          (N),
    .ADDR_WIDTH       (AW),
    .DATA_WIDTH       (DW),
    .MAX_DELAY_READY  (MAXA),
    .MAX_DELAY_RVALID (MAXR)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_resp    (rsp_resp),
    .araddr      (araddr),
    .arprot      (arprot),
    .arvalid     (arvalid),
    .arready     (arready),
    .rdata       (rdata),
    .rresp       (rresp),
    .rvalid      (rvalid),
    .rready      (rready),
    .timeout_err (timeout_err),
    .timeout_src (timeout_src)
  );

  int            n_vec = 0;
  int            n_err = 0;
  // Transaction-level model state
  int            model_last;
  bit            pend;
  int            pend_owner;
  logic [DW-1:0] pend_data;
  logic [1:0]    pend_resp;
  logic [DW-1:0] held_data;
  logic [1:0]    held_resp;
  logic [N-1:0]  seen_ready;

  function automatic logic [N-1:0] onehot(input int i);
    onehot = '0;
    if (i >= 0 && i < int'(N)) onehot[i] = 1'b1;
  endfunction

  // Round-robin rule: first requesting index after the last grant, modulo N.
  function automatic int rr_pick(input int last, input logic [N-1:0] mask);
    for (int k = 1; k <= int'(N); k++) begin
      if (mask[(last + k) % int'(N)]) return (last + k) % int'(N);
    end
    return -1;
  endfunction

  // Entered just after a rising edge with the DUT in IDLE. mask==0 makes it an idle cycle.
  task automatic run_txn(input logic [N-1:0] mask, input bit use_fixed,
                         input logic [AW-1:0] fixed_addr, input int d_ar, input int d_r,
                         input logic [DW-1:0] data, input logic [1:0] resp);
    int            w;
    logic [AW-1:0] exp_addr;
    logic [N-1:0]  exp_ready;
    logic          exp_to;
    logic [1:0]    exp_src;
    w = (mask == '0) ? -1 : rr_pick(model_last, mask);
    for (int i = 0; i < int'(N); i++) req_addr[i*AW +: AW] = $urandom;
    if (use_fixed && w >= 0) req_addr[w*AW +: AW] = fixed_addr;
    exp_addr  = (w >= 0) ? req_addr[w*AW +: AW] : '0;
    exp_ready = (w >= 0) ? onehot(w) : '0;
    req_valid = mask;
    @(negedge aclk);
    n_vec++;
    if (pend) begin
      if (rsp_valid !== onehot(pend_owner) || rsp_data !== pend_data || rsp_resp !== pend_resp)
      begin
        n_err++;
        $display("FAIL rsp: valid=%b data=%h resp=%b, want valid=%b data=%h resp=%b",
                 rsp_valid, rsp_data, rsp_resp, onehot(pend_owner), pend_data, pend_resp);
      end
      held_data = pend_data;
      held_resp = pend_resp;
    end else if (rsp_valid !== '0 || rsp_data !== held_data || rsp_resp !== held_resp) begin
      n_err++;
      $display("FAIL rsp_hold: valid=%b data=%h resp=%b, want valid=0 data=%h resp=%b",
               rsp_valid, rsp_data, rsp_resp, held_data, held_resp);
    end
    pend = 1'b0;
    n_vec++;
    seen_ready = req_ready;
    if (req_ready !== exp_ready) begin
      n_err++;
      $display("FAIL grant: req_ready=%b want %b (mask %b)", req_ready, exp_ready, mask);
    end
    n_vec++;
    if (arvalid !== 1'b0 || rready !== 1'b0 || timeout_err !== 1'b0 || timeout_src !== 2'b00
        || arprot !== 3'b000) begin
      n_err++;
      $display("FAIL idle_out: arvalid=%b rready=%b to=%b src=%b prot=%b want 0 0 0 00 000",
               arvalid, rready, timeout_err, timeout_src, arprot);
    end
    @(posedge aclk); #1;
    if (w < 0) return;
    model_last = w;
    for (int i = 0; i < int'(N); i++) req_addr[i*AW +: AW] = $urandom;
    for (int c = 0; c <= d_ar; c++) begin
      arready = (c == d_ar);
      rdata   = $urandom;
      @(negedge aclk);
      n_vec++;
      if (arvalid !== 1'b1 || araddr !== exp_addr || rready !== 1'b0 || req_ready !== '0
          || rsp_valid !== '0 || rsp_data !== held_data) begin
        n_err++;
        $display("FAIL ar_phase c=%0d: arvalid=%b araddr=%h rready=%b rdy=%b rsp=%b, want 1 %h 0 0 0",
                 c, arvalid, araddr, rready, req_ready, rsp_valid, exp_addr);
      end
      exp_to  = (c == int'(MAXA));
      exp_src = exp_to ? 2'b01 : 2'b00;
      n_vec++;
      if (timeout_err !== exp_to || timeout_src !== exp_src) begin
        n_err++;
        $display("FAIL ar_timeout c=%0d: err=%b src=%b want err=%b src=%b",
                 c, timeout_err, timeout_src, exp_to, exp_src);
      end
      @(posedge aclk); #1;
    end
    arready = 1'b0;
    for (int c = 0; c <= d_r; c++) begin
      rvalid = (c == d_r);
      rdata  = (c == d_r) ? data : DW'($urandom);
      rresp  = (c == d_r) ? resp : 2'($urandom);
      @(negedge aclk);
      n_vec++;
      if (rready !== 1'b1 || arvalid !== 1'b0 || req_ready !== '0 || rsp_valid !== '0
          || rsp_data !== held_data || rsp_resp !== held_resp) begin
        n_err++;
        $display("FAIL r_phase c=%0d: rready=%b arvalid=%b rdy=%b rsp=%b data=%h, want 1 0 0 0 %h",
                 c, rready, arvalid, req_ready, rsp_valid, rsp_data, held_data);
      end
      exp_to  = (c == int'(MAXR));
      exp_src = exp_to ? 2'b10 : 2'b00;
      n_vec++;
      if (timeout_err !== exp_to || timeout_src !== exp_src) begin
        n_err++;
        $display("FAIL r_timeout c=%0d: err=%b src=%b want err=%b src=%b",
                 c, timeout_err, timeout_src, exp_to, exp_src);
      end
      @(posedge aclk); #1;
    end
    rvalid     = 1'b0;
    req_valid  = '0;
    pend       = 1'b1;
    pend_owner = w;
    pend_data  = data;
    pend_resp  = resp;
  endtask

  task automatic test_reset();
    aresetn   = 1'b0;
    req_valid = '1;
    req_addr  = '1;
    arready   = 1'b1;
    rvalid    = 1'b1;
    rdata     = '1;
    rresp     = 2'b11;
    repeat (2) begin
      @(negedge aclk);
      n_vec++;
      if (req_ready !== '0 || rsp_valid !== '0 || rsp_data !== '0 || rsp_resp !== 2'b00
          || araddr !== '0 || arvalid !== 1'b0 || rready !== 1'b0 || timeout_err !== 1'b0
          || timeout_src !== 2'b00) begin
        n_err++;
        $display("FAIL reset: rdy=%b rsp=%b data=%h resp=%b araddr=%h arv=%b rr=%b to=%b src=%b want all 0",
                 req_ready, rsp_valid, rsp_data, rsp_resp, araddr, arvalid, rready, timeout_err,
                 timeout_src);
      end
    end
    aresetn   = 1'b1;
    req_valid = '0;
    arready   = 1'b0;
    rvalid    = 1'b0;
    model_last = int'(N) - 1;
    pend      = 1'b0;
    held_data = '0;
    held_resp = 2'b00;
    @(posedge aclk); #1;
  endtask

  task automatic test_fairness();
    for (int i = 0; i < 8; i++) begin
      run_txn('1, 1'b0, '0, $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 2'b00);
      n_vec++;
      if (seen_ready !== onehot(i % int'(N))) begin
        n_err++;
        $display("FAIL fairness #%0d: req_ready=%b want %b", i, seen_ready, onehot(i % int'(N)));
      end
    end
    run_txn('0, 1'b0, '0, 0, 0, '0, 2'b00);
  endtask

  task automatic test_single_read();
    run_txn(4'b0100, 1'b1, 32'h0000_1000, 0, 2, 32'hDEAD_BEEF, 2'b00);
    run_txn('0, 1'b0, '0, 0, 0, '0, 2'b00);
  endtask

  task automatic test_ar_timeout();
    run_txn(4'b0001, 1'b0, '0, 20, 1, $urandom, 2'b00);
    run_txn(4'b0010, 1'b0, '0, int'(MAXA) - 1, 0, $urandom, 2'b00);
    run_txn(4'b1000, 1'b0, '0, int'(MAXA), 0, $urandom, 2'b00);
    run_txn('0, 1'b0, '0, 0, 0, '0, 2'b00);
  endtask

  task automatic test_r_timeout_boundary();
    run_txn(4'b0100, 1'b0, '0, 0, int'(MAXR) - 1, $urandom, 2'b00);
    run_txn(4'b0100, 1'b0, '0, 1, int'(MAXR), $urandom, 2'b00);
    run_txn(4'b0010, 1'b0, '0, 0, 14, $urandom, 2'b00);
    run_txn('0, 1'b0, '0, 0, 0, '0, 2'b00);
  endtask

  task automatic test_error_resp();
    run_txn(4'b1010, 1'b0, '0, 1, 1, $urandom, 2'b10);
    run_txn(4'b1010, 1'b0, '0, 0, 3, $urandom, 2'b11);
    run_txn(4'b0001, 1'b0, '0, 2, 0, $urandom, 2'b01);
    run_txn('0, 1'b0, '0, 0, 0, '0, 2'b00);
  endtask

  task automatic test_reset_in_data();
    req_valid = 4'b0010;
    req_addr  = {N{32'hA5A5_0000}};
    @(posedge aclk); #1;
    arready = 1'b1;
    @(posedge aclk); #1;
    arready = 1'b0;
    @(posedge aclk); #1;
    #2;
    aresetn   = 1'b0;
    req_valid = '1;
    rvalid    = 1'b1;
    rdata     = $urandom;
    #1;
    n_vec++;
    if (arvalid !== 1'b0 || rready !== 1'b0 || req_ready !== '0 || rsp_valid !== '0
        || araddr !== '0 || rsp_data !== '0 || rsp_resp !== 2'b00 || timeout_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async: arv=%b rr=%b rdy=%b rsp=%b araddr=%h data=%h want all 0",
               arvalid, rready, req_ready, rsp_valid, araddr, rsp_data);
    end
    repeat (2) begin
      @(negedge aclk);
      n_vec++;
      if (rsp_valid !== '0 || req_ready !== '0 || arvalid !== 1'b0 || rready !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold: rsp=%b rdy=%b arv=%b rr=%b want 0", rsp_valid, req_ready,
                 arvalid, rready);
      end
    end
    aresetn    = 1'b1;
    rvalid     = 1'b0;
    req_valid  = '0;
    model_last = int'(N) - 1;
    pend       = 1'b0;
    held_data  = '0;
    held_resp  = 2'b00;
    @(posedge aclk); #1;
    run_txn('1, 1'b0, '0, 0, 1, $urandom, 2'b00);
    n_vec++;
    if (seen_ready !== onehot(0)) begin
      n_err++;
      $display("FAIL reset_first_grant: req_ready=%b want %b", seen_ready, onehot(0));
    end
    run_txn('0, 1'b0, '0, 0, 0, '0, 2'b00);
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      run_txn(N'($urandom_range(0, (1 << N) - 1)), 1'b0, '0, $urandom_range(0, 20),
              $urandom_range(0, 13), $urandom, 2'($urandom));
    end
    run_txn('0, 1'b0, '0, 0, 0, '0, 2'b00);
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_single_read();
    test_ar_timeout();
    test_r_timeout_boundary();
    test_error_resp();
    test_reset_in_data();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1);
  end

endmodule
